// File: rtl/hx711_emulator.sv
// HX711 device model: serves a held 24-bit sample on hx_dt, clocked by the driver's SCK.
// SCK-high power-down is built in only when HX711_EMU_PWRDN_EN is defined.
//   state   | meaning
//   CONVERT | conversion timer running, hx_dt high, gain-select pulses accepted
//   READY   | sample latched, hx_dt low, waiting for the first SCK rise
//   SHIFT   | sample bits leaving MSB-first on SCK rises
//   PWRDN   | SCK held high too long, waiting for SCK low
module hx711_emulator #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int CONV_CYC    = 5_000_000,
  parameter int PD_CYC      = 3_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hx_sck,
  output logic        hx_dt,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  output logic [1:0]  gain_sel,
  output logic        powered_down,
  output logic        frame_done,
  output logic        overrun,
  output logic        protocol_err
);

  localparam int CW = $clog2(CONV_CYC);

  if (CONV_CYC < 2 || PD_CYC < 2 || CLK_FREQ_HZ <= 0) begin : g_param_check
    $error("hx711_emulator: CONV_CYC and PD_CYC must be >= 2, CLK_FREQ_HZ positive");
  end

  typedef enum logic [1:0] {CONVERT, READY, SHIFT, PWRDN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [4:0]    pulse_cnt_q, pulse_cnt_d;
  logic [1:0]    gain_q, gain_d;
  logic [23:0]   shift_q, shift_d, hold_q, src;
  logic          hx_dt_d;
  logic          sck_s1, sck_s2, sck_prev;
  logic          sck_rise, sck_hi, conv_tc, pd_hit;

  assign sck_rise = sck_s2 & ~sck_prev;
  assign sck_hi   = sck_s2;
  assign conv_tc  = (conv_cnt_q == CW'(CONV_CYC - 1));
  assign gain_sel = gain_q;

`ifdef HX711_EMU_PWRDN_EN
  localparam int PW = $clog2(PD_CYC + 1);
  logic [PW-1:0] pd_cnt_q;
  logic          sck_fall;

  assign sck_fall = ~sck_s2 & sck_prev;

  // Saturates at PD_CYC so the trigger fires once per high period.
  always_ff @(posedge clk) begin
    if (rst || !sck_hi)             pd_cnt_q <= '0;
    else if (pd_cnt_q != PW'(PD_CYC)) pd_cnt_q <= pd_cnt_q + 1'b1;
  end

  assign pd_hit       = sck_hi && (pd_cnt_q == PW'(PD_CYC - 1));
  assign powered_down = (state_q == PWRDN);
`else
  assign pd_hit       = 1'b0;
  assign powered_down = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    conv_cnt_d   = conv_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    gain_d       = gain_q;
    shift_d      = shift_q;
    hx_dt_d      = hx_dt;
    src          = shift_q;
    frame_done   = 1'b0;
    overrun      = 1'b0;
    protocol_err = 1'b0;
    if (pd_hit) begin
      state_d = PWRDN;
      hx_dt_d = 1'b1;
    end else begin
      case (state_q)
        CONVERT: begin
          hx_dt_d    = 1'b1;
          conv_cnt_d = conv_cnt_q + 1'b1;
          if (sck_rise) begin
            case (pulse_cnt_q)
              5'd25:   begin pulse_cnt_d = 5'd26; gain_d = 2'd1; end
              5'd26:   begin pulse_cnt_d = 5'd27; gain_d = 2'd2; end
              default: protocol_err = 1'b1;
            endcase
          end
          if (conv_tc) begin
            conv_cnt_d  = '0;
            pulse_cnt_d = '0;
            shift_d     = sample_valid ? sample_in : hold_q;
            state_d     = READY;
            hx_dt_d     = 1'b0;
          end
        end
        READY: begin
          hx_dt_d    = 1'b0;
          conv_cnt_d = conv_tc ? '0 : conv_cnt_q + 1'b1;
          if (conv_tc) begin
            overrun = 1'b1;
            src     = hold_q;
          end
          shift_d = src;
          if (sck_rise) begin
            state_d     = SHIFT;
            pulse_cnt_d = 5'd1;
            hx_dt_d     = src[23];
            shift_d     = {src[22:0], 1'b0};
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            if (pulse_cnt_q == 5'd24) begin
              frame_done  = 1'b1;
              hx_dt_d     = 1'b1;
              gain_d      = 2'd0;
              conv_cnt_d  = '0;
              pulse_cnt_d = 5'd25;
              state_d     = CONVERT;
            end else begin
              hx_dt_d     = shift_q[23];
              shift_d     = {shift_q[22:0], 1'b0};
              pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
          end
        end
`ifdef HX711_EMU_PWRDN_EN
        PWRDN: begin
          hx_dt_d = 1'b1;
          if (sck_fall) begin
            state_d     = CONVERT;
            conv_cnt_d  = '0;
            pulse_cnt_d = '0;
            gain_d      = 2'd0;
          end
        end
`endif
        default: begin
          state_d = CONVERT;
          hx_dt_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1      <= 1'b0;
      sck_s2      <= 1'b0;
      sck_prev    <= 1'b0;
      state_q     <= CONVERT;
      conv_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      gain_q      <= 2'd0;
      shift_q     <= '0;
      hold_q      <= '0;
      hx_dt       <= 1'b1;
    end else begin
      sck_s1      <= hx_sck;
      sck_s2      <= sck_s1;
      sck_prev    <= sck_s2;
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      gain_q      <= gain_d;
      shift_q     <= shift_d;
      hx_dt       <= hx_dt_d;
      if (sample_valid) hold_q <= sample_in;
    end
  end

endmodule
